// File: rtl/wb_stage.sv
// RV32I writeback stage: arbitrates ALU results against load responses, formats
// load data, drives the register-file write port and tracks pending loads.
module wb_stage #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        wb_stall,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_query,
  input  logic [4:0]  rs2_query,
  output logic        load_hazard,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        reg_write
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef struct packed {
    logic        vld;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  logic [3:0]  starve_cnt;
  logic [31:0] sb, sb_set, sb_clr, sb_nxt;
  logic        force_ld;
  logic [31:0] ld_fmt;
  wb_req_t     sel;

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // A starved load preempts the ALU, which is the only time execute is held.
  assign force_ld = ld_valid && (starve_cnt == SMAX);
  assign ld_ready = force_ld || (ld_valid && !alu_valid);
  assign wb_stall = force_ld && alu_valid;
  assign ld_fmt   = fmt_load(ld_data, ld_funct3, ld_addr_lo);

  always_comb begin
    sel = '0;
    if (ld_ready)       sel = '{vld: 1'b1, rd: ld_rd,  data: ld_fmt};
    else if (alu_valid) sel = '{vld: 1'b1, rd: alu_rd, data: alu_data};
  end

  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (issue_valid) sb_set[issue_rd] = 1'b1;
    if (ld_ready)    sb_clr[ld_rd]    = 1'b1;
    // Set is applied after clear so a same-cycle reissue keeps the bit pending.
    sb_nxt = ((sb & ~sb_clr) | sb_set) & ~32'h1;
  end

  assign load_hazard = sb[rs1_query] || sb[rs2_query];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      sb         <= '0;
      rd_addr    <= '0;
      rd_data    <= '0;
      reg_write  <= 1'b0;
    end else begin
      sb <= sb_nxt;
      if (!ld_valid || ld_ready)   starve_cnt <= '0;
      else if (starve_cnt != SMAX) starve_cnt <= starve_cnt + 4'd1;
      reg_write <= sel.vld && (sel.rd != 5'd0);
      if (sel.vld) begin
        rd_addr <= sel.rd;
        rd_data <= sel.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for single-cycle writes plus
// sequences for starvation, scoreboard and reset behaviour.
module tb_wb_stage;
  localparam int SM = 4;

  logic        clock = 1'b0, reset = 1'b1;
  logic        alu_valid, ld_valid, issue_valid;
  logic [4:0]  alu_rd, ld_rd, issue_rd, rs1_query, rs2_query;
  logic [31:0] alu_data, ld_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        wb_stall, ld_ready, load_hazard, reg_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  int n_cmp = 0, n_bad = 0;

  wb_stage #(.STARVE_MAX(SM)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .wb_stall(wb_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_query(rs1_query), .rs2_query(rs2_query), .load_hazard(load_hazard),
    .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write)
  );

  always #5 clock = ~clock;

  // Decode must never reissue to a pending rd unless that load retires the same cycle.
  logic [31:0] tb_pend;
  always @(posedge clock or posedge reset) begin
    if (reset) tb_pend <= '0;
    else begin
      assert (!(issue_valid && issue_rd != 0 && tb_pend[issue_rd] &&
                !(ld_valid && ld_rd == issue_rd)))
        else $error("issue to pending rd %0d", issue_rd);
      tb_pend <= (tb_pend & ~(ld_valid ? (32'd1 << ld_rd) : 32'd0)) |
                 ((issue_valid && issue_rd != 0) ? (32'd1 << issue_rd) : 32'd0);
    end
  end

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] adat;
    logic lv; logic [4:0] lrd; logic [31:0] ldat; logic [2:0] f3; logic [1:0] lo;
    logic e_rdy; logic e_stall; logic e_we; logic [4:0] e_rd; logic [31:0] e_dat;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0; ld_funct3 = 0; ld_addr_lo = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [31:0] d, input logic [2:0] f3);
    ld_valid = 1; ld_rd = rd; ld_data = d; ld_funct3 = f3; ld_addr_lo = 0;
  endtask

  initial begin
    idle();
    rs1_query = 0; rs2_query = 0;
    #1;
    chk("reset reg_write", {31'd0, reg_write}, 0);
    chk("reset rd_addr", {27'd0, rd_addr}, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset hazard", {31'd0, load_hazard}, 0);
    @(negedge clock); reset = 0;

    //          av ard adat      lv lrd ldat          f3    lo  rdy stl we rd dat
    vt[0]  = '{0, 0, 0,         1, 3, 32'h80007F80, 3'b000, 0, 1, 0, 1, 3, 32'hFFFFFF80};
    vt[1]  = '{0, 0, 0,         1, 4, 32'h80007F80, 3'b100, 1, 1, 0, 1, 4, 32'h0000007F};
    vt[2]  = '{0, 0, 0,         1, 5, 32'h80007F80, 3'b101, 2, 1, 0, 1, 5, 32'h00008000};
    vt[3]  = '{0, 0, 0,         1, 6, 32'h80007F80, 3'b001, 2, 1, 0, 1, 6, 32'hFFFF8000};
    vt[4]  = '{0, 0, 0,         1, 6, 32'h80007F80, 3'b001, 3, 1, 0, 1, 6, 32'hFFFF8000};
    vt[5]  = '{0, 0, 0,         1, 8, 32'h80007F80, 3'b010, 1, 1, 0, 1, 8, 32'h80007F80};
    vt[6]  = '{0, 0, 0,         1, 8, 32'h80007F80, 3'b100, 3, 1, 0, 1, 8, 32'h00000080};
    vt[7]  = '{0, 0, 0,         1, 2, 32'h80007F80, 3'b000, 1, 1, 0, 1, 2, 32'h0000007F};
    vt[8]  = '{0, 0, 0,         1, 2, 32'h12345678, 3'b011, 2, 1, 0, 1, 2, 32'h12345678};
    vt[9]  = '{1, 5, 32'h1234,  0, 0, 0,            3'b000, 0, 0, 0, 1, 5, 32'h00001234};
    vt[10] = '{1, 0, 32'hBEEF,  0, 0, 0,            3'b000, 0, 0, 0, 0, 0, 32'h0000BEEF};
    vt[11] = '{1, 9, 32'h55AA,  1, 3, 32'hFFFFFFFF, 3'b010, 0, 0, 0, 1, 9, 32'h000055AA};
    vt[12] = '{0, 0, 0,         1, 0, 32'hAAAAAAAA, 3'b010, 0, 1, 0, 0, 0, 32'hAAAAAAAA};
    vt[13] = '{0, 0, 0,         1, 1, 32'h1234ABCD, 3'b101, 0, 1, 0, 1, 1, 32'h0000ABCD};

    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].adat;
      ld_valid = vt[i].lv; ld_rd = vt[i].lrd; ld_data = vt[i].ldat;
      ld_funct3 = vt[i].f3; ld_addr_lo = vt[i].lo;
      #1;
      chk($sformatf("v%0d ld_ready", i), {31'd0, ld_ready}, {31'd0, vt[i].e_rdy});
      chk($sformatf("v%0d wb_stall", i), {31'd0, wb_stall}, {31'd0, vt[i].e_stall});
      @(posedge clock); #1;
      chk($sformatf("v%0d reg_write", i), {31'd0, reg_write}, {31'd0, vt[i].e_we});
      chk($sformatf("v%0d rd_addr", i), {27'd0, rd_addr}, {27'd0, vt[i].e_rd});
      chk($sformatf("v%0d rd_data", i), rd_data, vt[i].e_dat);
      @(negedge clock); idle();
      @(posedge clock); #1;
      chk($sformatf("v%0d idle reg_write", i), {31'd0, reg_write}, 0);
      chk($sformatf("v%0d hold rd_addr", i), {27'd0, rd_addr}, {27'd0, vt[i].e_rd});
      chk($sformatf("v%0d hold rd_data", i), rd_data, vt[i].e_dat);
    end

    // Starvation: ALU wins SM cycles, then the load is forced and the ALU stalls.
    for (int c = 0; c <= SM + 1; c++) begin
      @(negedge clock);
      alu_valid = 1; alu_rd = 10; alu_data = 32'h100 + c;
      load(11, 32'hCAFE0000, 3'b010);
      #1;
      chk($sformatf("starve c%0d ld_ready", c), {31'd0, ld_ready}, (c == SM) ? 1 : 0);
      chk($sformatf("starve c%0d wb_stall", c), {31'd0, wb_stall}, (c == SM) ? 1 : 0);
      @(posedge clock); #1;
      chk($sformatf("starve c%0d reg_write", c), {31'd0, reg_write}, 1);
      chk($sformatf("starve c%0d rd_addr", c), {27'd0, rd_addr}, (c == SM) ? 11 : 10);
      chk($sformatf("starve c%0d rd_data", c), rd_data,
          (c == SM) ? 32'hCAFE0000 : 32'h100 + c);
    end
    @(negedge clock); idle();

    // Scoreboard: issue rd7, hazard next cycle, clear one cycle after the load.
    @(negedge clock);
    issue_valid = 1; issue_rd = 7; rs1_query = 7; rs2_query = 0;
    #1 chk("hz issue cycle", {31'd0, load_hazard}, 0);
    @(negedge clock); idle();
    #1 chk("hz after issue", {31'd0, load_hazard}, 1);
    rs1_query = 0;
    #1 chk("hz x0 query", {31'd0, load_hazard}, 0);
    rs1_query = 7;
    @(negedge clock); load(7, 32'h1, 3'b010);
    #1 chk("hz load cycle", {31'd0, load_hazard}, 1);
    @(negedge clock); idle();
    #1 chk("hz cleared", {31'd0, load_hazard}, 0);
    @(negedge clock); issue_valid = 1; issue_rd = 0;
    @(negedge clock); idle(); rs1_query = 0; rs2_query = 0;
    #1 chk("hz issue x0", {31'd0, load_hazard}, 0);

    // Same-cycle set and clear of rd9: set wins.
    rs1_query = 9;
    @(negedge clock); issue_valid = 1; issue_rd = 9;
    @(negedge clock); idle(); load(9, 32'h2, 3'b010); issue_valid = 1; issue_rd = 9;
    #1 chk("same-cycle ld_ready", {31'd0, ld_ready}, 1);
    @(negedge clock); idle();
    #1 chk("same-cycle set wins", {31'd0, load_hazard}, 1);
    @(negedge clock); load(9, 32'h3, 3'b010);
    @(negedge clock); idle();
    #1 chk("rd9 cleared", {31'd0, load_hazard}, 0);

    // Reset mid-stream with a pending load and a write on the port.
    @(negedge clock); issue_valid = 1; issue_rd = 12; rs1_query = 12;
    @(negedge clock); idle(); load(13, 32'h77, 3'b010);
    @(posedge clock); #1;
    chk("pre-reset reg_write", {31'd0, reg_write}, 1);
    chk("pre-reset hazard", {31'd0, load_hazard}, 1);
    idle(); reset = 1;
    #1;
    chk("mid reset reg_write", {31'd0, reg_write}, 0);
    chk("mid reset rd_addr", {27'd0, rd_addr}, 0);
    chk("mid reset rd_data", rd_data, 0);
    chk("mid reset hazard", {31'd0, load_hazard}, 0);
    @(negedge clock); reset = 0;
    @(negedge clock);
    chk("post reset hazard", {31'd0, load_hazard}, 0);
    alu_valid = 1; alu_rd = 20; alu_data = 32'h5;
    @(posedge clock); #1;
    chk("post reset alu write", {27'd0, rd_addr}, 20);
    @(negedge clock); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
